// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters kclk/kdata, deserialises
// 11-bit frames, checks start/odd-parity/stop, and recovers from stalled frames by timeout.
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kclk,
  input  logic        kdata,
  output logic [15:0] keycode,
  output logic [7:0]  scan_byte,
  output logic        oflag,
  output logic        err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Line index 0 is kclk, index 1 is kdata.
  logic [1:0]    r_sync1, r_sync2, r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_kclk_prev;

  state_t        r_state, w_state_next;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bit_cnt;
  logic          r_parity;
  logic [TW-1:0] r_tcnt;

  logic          w_strobe, w_bit;
  logic          w_accept, w_reject, w_timeout;

  // NOTE: every register below is written with non-blocking assignments so that all
  // flops sample the pre-edge values of their neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_filt      <= '1;
      r_fcnt[0]   <= '0;
      r_fcnt[1]   <= '0;
      r_kclk_prev <= 1'b1;
    end else begin
      r_sync1     <= {kdata, kclk};
      r_sync2     <= r_sync1;
      r_kclk_prev <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign w_strobe = r_kclk_prev & ~r_filt[0];
  assign w_bit    = r_filt[1];

  // NOTE: every output of this block is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE:   if (w_strobe && !w_bit) w_state_next = S_DATA;
      S_DATA:   if (w_strobe && r_bit_cnt == 3'd7) w_state_next = S_PARITY;
      S_PARITY: if (w_strobe) w_state_next = S_STOP;
      S_STOP: begin
        if (w_strobe) begin
          w_state_next = S_IDLE;
          if (w_bit && (^{r_shreg, r_parity})) w_accept = 1'b1;
          else                                 w_reject = 1'b1;
        end
      end
      default:  w_state_next = S_IDLE;
    endcase
    // A strobe landing on the terminal count wins over the timeout.
    if (r_state != S_IDLE && !w_strobe && r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
      w_state_next = S_IDLE;
      w_timeout    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_tcnt    <= '0;
      keycode   <= '0;
      scan_byte <= '0;
      oflag     <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (r_state == S_IDLE || w_strobe || w_timeout) r_tcnt <= '0;
      else                                            r_tcnt <= r_tcnt + TW'(1);

      if (w_strobe) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= '0;
          S_DATA: begin
            r_shreg   <= {w_bit, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_parity <= w_bit;
          default:  ;
        endcase
      end

      if (w_accept) begin
        scan_byte <= r_shreg;
        keycode   <= {keycode[7:0], r_shreg};
      end
      oflag <= w_accept;
      err   <= w_reject | w_timeout;
    end
  end

endmodule
